tcp_decoder: RTL and testbench
==============================

// Module: tcp_decoder
// PURPOSE
//  Receive-side TCP layer: takes one full TCP segment (header+payload) per rx_valid beat,
//  verifies pseudo-header checksum and destination port, tracks a single-connection
//  LISTEN/SYN_RCVD/ESTABLISHED state with expected sequence number, and delivers PUSH
//  payloads to the FIX parser. Sits between the IP decoder and the FIX message decoder.
// PARAMETERS
//  PAYLOAD_LEN        262           payload bytes per segment
//  TCPH_LEN           20            TCP header bytes (no options)
//  PSEUDO_HEADER_LEN  12            pseudo-header bytes for checksum
//  PROTOCOL           6             protocol byte in pseudo header
//  SRCADDR            32'h7f000001  peer IP, pseudo-header word 0
//  DESADDR            32'h7f000001  local IP, pseudo-header word 1
//  LOCAL_PORT         16'd9000      required destination port
// PORTS
//  clk            in   1                      clock
//  rst_n          in   1                      reset, synchronous, active-low
//  rx_valid       in   1                      rx_tcp_data holds a segment this cycle
//  rx_tcp_data    in   (PAYLOAD_LEN+TCPH_LEN)*8  segment, byte 0 at MSB
//  tx_valid       out  1                      1-cycle pulse: tx_fix_data valid (PUSH delivered)
//  tx_fix_data    out  PAYLOAD_LEN*8          delivered payload
//  seg_valid      out  1                      1-cycle pulse: any segment accepted
//  rx_flag        out  6                      flags of last accepted segment
//  rx_seq_num     out  32                     seq of last accepted segment
//  rx_ack_num     out  32                     ack of last accepted segment
//  rx_adv_window  out  16                     window of last accepted segment
//  conn_state     out  2                      0 LISTEN, 1 SYN_RCVD, 2 ESTABLISHED
//  csum_err       out  1                      1-cycle pulse: checksum mismatch
//  drop_cnt       out  16                     dropped segments, saturating at 16'hFFFF
// BEHAVIOUR
//  Header fields MSB-first: src port 16, dst port 16, seq 32, ack 32, hdrlen 4, rsvd 6,
//   flags 6, window 16, checksum 16, urgptr 16, then payload. Flags: bit0 FIN, 1 SYN,
//   2 RST, 3 PUSH, 4 ACK, 5 URG. Source port is not checked.
//  Reset: all outputs 0, conn_state LISTEN, exp_seq 0, stage-1 valid cleared; a segment
//   in flight when rst_n goes low is discarded with no output pulse.
//  Pipeline, no backpressure: edge k captures segment (rx_valid=1) into stage 1; checksum
//   computed combinationally on stage 1; edge k+1 registers decision and all outputs.
//   Back-to-back segments accepted every cycle; segment k+1 sees state written by k.
//  Checksum: ones-complement over {pseudo header, segment with checksum field = 0};
//   pseudo length field = TCPH_LEN+PAYLOAD_LEN. Mismatch vs received field -> drop,
//   csum_err=1, drop_cnt+1, no state change. Checksum error takes priority over all.
//  dst port != LOCAL_PORT -> drop, drop_cnt+1 (csum_err 0).
//  RST set (valid csum/port) in any state -> LISTEN, accepted, seg_valid=1.
//  LISTEN: SYN -> SYN_RCVD, exp_seq=seq+1, accepted; anything else -> drop.
//  SYN_RCVD: ACK and seq==exp_seq -> ESTABLISHED, exp_seq+1; else drop.
//  ESTABLISHED, seq==exp_seq required (else drop), then exp_seq+1 and:
//   PUSH (flag[3]) -> tx_valid=1, tx_fix_data=payload; FIN -> LISTEN;
//   pure ACK -> no delivery; SYN -> drop (no exp_seq advance).
//  Accepted segment updates rx_flag/rx_seq_num/rx_ack_num/rx_adv_window and pulses
//   seg_valid; dropped segments leave them held. tx_fix_data holds between pulses.
//  exp_seq arithmetic modulo 2^32 (32'hFFFFFFFF+1 = 0). drop_cnt saturates, no wrap.
//  Illegal conn_state 2'd3 -> LISTEN next cycle.
// STRUCTURE
//  tcp_pkg: flag bit constants (FIN..URG), state encodings, header field offsets/widths,
//   pseudo-header builder function; shared with tcp_encoder.
//  Sub-module: existing checksum instance, SIZE=(PAYLOAD_LEN+TCPH_LEN+PSEUDO_HEADER_LEN)*8.
// TESTING
//  1 rst_n=0 then 1 -> all outputs 0, conn_state=0, drop_cnt=0.
//  2 SYN seq=32'h12341234 good csum -> after edge+1 seg_valid=1, conn_state=1, rx_flag=6'h02.
//  3 ACK seq=32'h12341235, then PUSH seq=32'h12341236 payload 8'hA5 pattern -> state 2;
//    tx_valid 1 cycle, tx_fix_data=all 8'hA5; PUSH replayed same seq -> drop_cnt=1.
//  4 PUSH with one payload bit flipped -> csum_err=1, tx_valid=0, drop_cnt+1, state kept.
//  5 SYN seq=32'hFFFFFFFE, ACK 32'hFFFFFFFF, PUSH 32'h00000000 back-to-back -> all accepted.
//  6 RST in ESTABLISHED -> conn_state=0; rst_n low the cycle after a PUSH -> no tx_valid.

Source files
------------

// File: rtl/tcp_decoder_pkg.sv
// Shared TCP definitions: flag bit positions, connection states, header field
// offsets (bits from the MSB of the segment, byte 0 first) and a pseudo-header builder.
package tcp_decoder_pkg;

  typedef enum logic [2:0] {
    FlagFin = 3'd0,
    FlagSyn = 3'd1,
    FlagRst = 3'd2,
    FlagPsh = 3'd3,
    FlagAck = 3'd4,
    FlagUrg = 3'd5
  } tcp_flag_e;

  typedef enum logic [1:0] {
    StListen      = 2'd0,
    StSynRcvd     = 2'd1,
    StEstablished = 2'd2,
    StIllegal     = 2'd3
  } conn_state_e;

  localparam int unsigned OFF_DST_PORT = 16;
  localparam int unsigned OFF_SEQ      = 32;
  localparam int unsigned OFF_ACK      = 64;
  localparam int unsigned OFF_FLAGS    = 106;
  localparam int unsigned OFF_WINDOW   = 112;
  localparam int unsigned OFF_CSUM     = 128;

  // {src addr, dst addr, zero, protocol, TCP length}
  function automatic logic [95:0] pseudo_header(input logic [31:0] src, input logic [31:0] dst,
                                                input logic [7:0] proto, input logic [15:0] len);
    return {src, dst, 8'h00, proto, len};
  endfunction

endpackage

// File: rtl/tcp_decoder_if.sv
// Segment-in / payload-out bus of the TCP decoder.
//  rx_valid, rx_tcp_data : one full segment per beat (master -> slave)
//  tx_valid, tx_fix_data : delivered PUSH payload (slave -> master)
interface tcp_decoder_if #(
  parameter int unsigned PAYLOAD_LEN = 262,
  parameter int unsigned TCPH_LEN    = 20
);
  logic                                  rx_valid;
  logic [(PAYLOAD_LEN+TCPH_LEN)*8-1:0]   rx_tcp_data;
  logic                                  tx_valid;
  logic [PAYLOAD_LEN*8-1:0]              tx_fix_data;

  modport master (output rx_valid, output rx_tcp_data, input tx_valid, input tx_fix_data);
  modport slave  (input rx_valid, input rx_tcp_data, output tx_valid, output tx_fix_data);
endinterface

// File: rtl/tcp_decoder_checksum.sv
// Combinational internet checksum (ones-complement of the ones-complement sum of
// 16-bit big-endian words).
//  data : SIZE bits, first word at MSB (SIZE must be a multiple of 16)
//  csum : checksum value to place in / compare against the header field
module tcp_decoder_checksum #(
  parameter int unsigned SIZE = 2352
) (
  input  logic [SIZE-1:0] data,
  output logic [15:0]     csum
);
  localparam int unsigned NumWords = SIZE / 16;

  logic [31:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      sum = sum + {16'd0, data[SIZE-1-16*i -: 16]};
    end
    // Two folds suffice: after the first the carry is at most 1 and cannot ripple out again.
    fold1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    fold2 = fold1[15:0] + {15'd0, fold1[16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/tcp_decoder.sv
// Receive-side TCP for a single connection. Stage 1 captures a segment; the next edge
// registers the checksum/port/state decision and all outputs.
//  clk, rst_n    : clock, synchronous active-low reset
//  bus (slave)   : rx_valid/rx_tcp_data in, tx_valid/tx_fix_data out (PUSH payload)
//  seg_valid     : pulse, segment accepted
//  rx_flag/rx_seq_num/rx_ack_num/rx_adv_window : fields of last accepted segment
//  conn_state    : 0 LISTEN, 1 SYN_RCVD, 2 ESTABLISHED
//  csum_err      : pulse, checksum mismatch
//  drop_cnt      : saturating count of dropped segments
module tcp_decoder
  import tcp_decoder_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN       = 262,
  parameter int unsigned TCPH_LEN          = 20,
  parameter int unsigned PSEUDO_HEADER_LEN = 12,
  parameter logic [7:0]  PROTOCOL          = 8'd6,
  parameter logic [31:0] SRCADDR           = 32'h7f000001,
  parameter logic [31:0] DESADDR           = 32'h7f000001,
  parameter logic [15:0] LOCAL_PORT        = 16'd9000
) (
  input  logic         clk,
  input  logic         rst_n,
  tcp_decoder_if.slave bus,
  output logic         seg_valid,
  output logic [5:0]   rx_flag,
  output logic [31:0]  rx_seq_num,
  output logic [31:0]  rx_ack_num,
  output logic [15:0]  rx_adv_window,
  output logic [1:0]   conn_state,
  output logic         csum_err,
  output logic [15:0]  drop_cnt
);
  localparam int unsigned SegW  = (PAYLOAD_LEN + TCPH_LEN) * 8;
  localparam int unsigned PayW  = PAYLOAD_LEN * 8;
  localparam int unsigned CsumW = (PAYLOAD_LEN + TCPH_LEN + PSEUDO_HEADER_LEN) * 8;
  localparam logic [15:0] SegLen = 16'(PAYLOAD_LEN + TCPH_LEN);

  logic            s1_valid_q;
  logic [SegW-1:0] s1_seg_q;
  logic [SegW-1:0] seg_zeroed;
  logic [15:0]     csum_calc;

  logic [15:0] seg_dst, seg_csum, seg_win;
  logic [31:0] seg_seq, seg_ack;
  logic [5:0]  seg_flags;

  conn_state_e state_q, state_d;
  logic [31:0] exp_seq_q, exp_seq_d;
  logic        accept, deliver, drop, csum_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.rx_valid;
    end
    if (bus.rx_valid) s1_seg_q <= bus.rx_tcp_data;
  end

  assign seg_dst   = s1_seg_q[SegW-1-OFF_DST_PORT -: 16];
  assign seg_seq   = s1_seg_q[SegW-1-OFF_SEQ -: 32];
  assign seg_ack   = s1_seg_q[SegW-1-OFF_ACK -: 32];
  assign seg_flags = s1_seg_q[SegW-1-OFF_FLAGS -: 6];
  assign seg_win   = s1_seg_q[SegW-1-OFF_WINDOW -: 16];
  assign seg_csum  = s1_seg_q[SegW-1-OFF_CSUM -: 16];

  always_comb begin
    seg_zeroed = s1_seg_q;
    seg_zeroed[SegW-1-OFF_CSUM -: 16] = 16'd0;
  end

  tcp_decoder_checksum #(
    .SIZE(CsumW)
  ) u_checksum (
    .data({pseudo_header(SRCADDR, DESADDR, PROTOCOL, SegLen), seg_zeroed}),
    .csum(csum_calc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StListen;
      exp_seq_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      exp_seq_q <= exp_seq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_seq_d = exp_seq_q;
    accept    = 1'b0;
    deliver   = 1'b0;
    drop      = 1'b0;
    csum_bad  = 1'b0;
    if (state_q == StIllegal) state_d = StListen;
    if (s1_valid_q) begin
      if (csum_calc != seg_csum) begin
        csum_bad = 1'b1;
        drop     = 1'b1;
      end else if (seg_dst != LOCAL_PORT) begin
        drop = 1'b1;
      end else if (seg_flags[FlagRst]) begin
        state_d = StListen;
        accept  = 1'b1;
      end else begin
        case (state_q)
          StListen: begin
            if (seg_flags[FlagSyn]) begin
              state_d   = StSynRcvd;
              exp_seq_d = seg_seq + 32'd1;
              accept    = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
          StSynRcvd: begin
            if (seg_flags[FlagAck] && seg_seq == exp_seq_q) begin
              state_d   = StEstablished;
              exp_seq_d = exp_seq_q + 32'd1;
              accept    = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
          StEstablished: begin
            // A SYN inside an open connection is rejected without consuming a sequence number.
            if (seg_seq != exp_seq_q || seg_flags[FlagSyn]) begin
              drop = 1'b1;
            end else begin
              exp_seq_d = exp_seq_q + 32'd1;
              accept    = 1'b1;
              deliver   = seg_flags[FlagPsh];
              if (seg_flags[FlagFin]) state_d = StListen;
            end
          end
          default: drop = 1'b1;
        endcase
      end
    end
  end

  assign conn_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_valid       <= 1'b0;
      csum_err        <= 1'b0;
      bus.tx_valid    <= 1'b0;
      bus.tx_fix_data <= '0;
      rx_flag         <= 6'd0;
      rx_seq_num      <= 32'd0;
      rx_ack_num      <= 32'd0;
      rx_adv_window   <= 16'd0;
      drop_cnt        <= 16'd0;
    end else begin
      seg_valid    <= accept;
      csum_err     <= csum_bad;
      bus.tx_valid <= deliver;
      if (deliver) bus.tx_fix_data <= s1_seg_q[PayW-1:0];
      if (accept) begin
        rx_flag       <= seg_flags;
        rx_seq_num    <= seg_seq;
        rx_ack_num    <= seg_ack;
        rx_adv_window <= seg_win;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tcp_decoder.sv
module tb_tcp_decoder;
  import tcp_decoder_pkg::*;

  localparam int unsigned PAYLOAD_LEN = 262;
  localparam int unsigned TCPH_LEN    = 20;
  localparam int unsigned SEG_BYTES   = PAYLOAD_LEN + TCPH_LEN;
  localparam int unsigned SEG_W       = SEG_BYTES * 8;
  localparam int unsigned PAY_W       = PAYLOAD_LEN * 8;
  localparam logic [15:0] LPORT       = 16'd9000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_at_edge = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= rst_n;

  tcp_decoder_if #(.PAYLOAD_LEN(PAYLOAD_LEN), .TCPH_LEN(TCPH_LEN)) bus ();

  logic        seg_valid, csum_err;
  logic [5:0]  rx_flag;
  logic [31:0] rx_seq_num, rx_ack_num;
  logic [15:0] rx_adv_window, drop_cnt;
  logic [1:0]  conn_state;

  tcp_decoder #(.PAYLOAD_LEN(PAYLOAD_LEN), .TCPH_LEN(TCPH_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .seg_valid(seg_valid), .rx_flag(rx_flag), .rx_seq_num(rx_seq_num),
    .rx_ack_num(rx_ack_num), .rx_adv_window(rx_adv_window), .conn_state(conn_state),
    .csum_err(csum_err), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic             seg_valid, csum_err, tx_valid;
    logic [1:0]       state;
    logic [15:0]      drop;
    logic [5:0]       flag;
    logic [31:0]      seq, ack;
    logic [15:0]      win;
    logic [PAY_W-1:0] tx_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [15:0] prev_drop = 16'd0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference connection model
  int               m_state;
  logic [31:0]      m_exp;
  logic [15:0]      m_drop, m_win;
  logic [5:0]       m_flag;
  logic [31:0]      m_seq, m_ack;
  logic [PAY_W-1:0] m_tx;
  byte unsigned     sb[SEG_BYTES];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] model_csum();
    int unsigned sum = 0;
    byte unsigned ph[12];
    ph = '{8'h7f, 8'h00, 8'h00, 8'h01, 8'h7f, 8'h00, 8'h00, 8'h01, 8'h00, 8'h06,
           8'(SEG_BYTES >> 8), 8'(SEG_BYTES)};
    for (int i = 0; i < 12; i += 2) sum += {16'd0, ph[i], ph[i+1]};
    for (int i = 0; i < int'(SEG_BYTES); i += 2) if (i != 16) sum += {16'd0, sb[i], sb[i+1]};
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    return ~(16'(sum));
  endfunction

  task automatic build(input logic [15:0] dst, input logic [31:0] seq, input logic [31:0] ack,
                       input logic [5:0] fl, input logic [15:0] win, input bit rnd_pay,
                       input logic [7:0] pat);
    logic [15:0] cs;
    sb[0] = 8'($urandom); sb[1] = 8'($urandom);
    sb[2] = dst[15:8];    sb[3] = dst[7:0];
    for (int i = 0; i < 4; i++) begin
      sb[4+i] = seq[31-8*i -: 8];
      sb[8+i] = ack[31-8*i -: 8];
    end
    sb[12] = 8'h50; sb[13] = {2'b00, fl};
    sb[14] = win[15:8]; sb[15] = win[7:0];
    sb[16] = 8'h00; sb[17] = 8'h00; sb[18] = 8'h00; sb[19] = 8'h00;
    for (int i = 20; i < int'(SEG_BYTES); i++) sb[i] = rnd_pay ? 8'($urandom) : pat;
    cs = model_csum();
    sb[16] = cs[15:8]; sb[17] = cs[7:0];
  endtask

  task automatic model_reset();
    m_state = 0; m_exp = 0; m_drop = 0; m_flag = 0; m_seq = 0; m_ack = 0; m_win = 0;
    m_tx = '0;
    exp_q.delete();
  endtask

  // Predict the response to sb (when track), then drive it for one cycle.
  task automatic issue(input bit track);
    exp_t e;
    logic [15:0] dst;
    logic [31:0] seq, ack;
    logic [5:0]  fl;
    logic [SEG_W-1:0] v;
    bit acc, del;
    dst = {sb[2], sb[3]};
    seq = {sb[4], sb[5], sb[6], sb[7]};
    ack = {sb[8], sb[9], sb[10], sb[11]};
    fl  = sb[13][5:0];
    if (track) begin
      acc = 0; del = 0; e.csum_err = 0;
      if (model_csum() != {sb[16], sb[17]}) begin
        e.csum_err = 1;
      end else if (dst != LPORT) begin
        acc = 0;
      end else if (fl[2]) begin
        m_state = 0; acc = 1;
      end else if (m_state == 0) begin
        if (fl[1]) begin m_state = 1; m_exp = seq + 32'd1; acc = 1; end
      end else if (m_state == 1) begin
        if (fl[4] && seq == m_exp) begin m_state = 2; m_exp = m_exp + 32'd1; acc = 1; end
      end else begin
        if (seq == m_exp && !fl[1]) begin
          m_exp = m_exp + 32'd1; acc = 1; del = fl[3];
          if (fl[0]) m_state = 0;
        end
      end
      if (acc) begin
        m_flag = fl; m_seq = seq; m_ack = ack; m_win = {sb[14], sb[15]};
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
      if (del) for (int i = 0; i < int'(PAYLOAD_LEN); i++) m_tx[PAY_W-1-8*i -: 8] = sb[20+i];
      e.seg_valid = acc; e.tx_valid = del; e.state = 2'(m_state); e.drop = m_drop;
      e.flag = m_flag; e.seq = m_seq; e.ack = m_ack; e.win = m_win; e.tx_data = m_tx;
      exp_q.push_back(e);
    end
    for (int i = 0; i < int'(SEG_BYTES); i++) v[SEG_W-1-8*i -: 8] = sb[i];
    bus.rx_tcp_data = v;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every output event (accept pulse, checksum pulse, drop count step) pops one entry.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_at_edge) begin
        prev_drop = 16'd0;
      end else if (seg_valid || csum_err || bus.tx_valid || drop_cnt != prev_drop) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: seg_valid=%0b csum_err=%0b drop_cnt=%0d, none expected",
                   seg_valid, csum_err, drop_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          chk("seg_valid", 64'(seg_valid), 64'(mon_e.seg_valid));
          chk("csum_err", 64'(csum_err), 64'(mon_e.csum_err));
          chk("tx_valid", 64'(bus.tx_valid), 64'(mon_e.tx_valid));
          chk("conn_state", 64'(conn_state), 64'(mon_e.state));
          chk("drop_cnt", 64'(drop_cnt), 64'(mon_e.drop));
          chk("rx_flag", 64'(rx_flag), 64'(mon_e.flag));
          chk("rx_seq_num", 64'(rx_seq_num), 64'(mon_e.seq));
          chk("rx_ack_num", 64'(rx_ack_num), 64'(mon_e.ack));
          chk("rx_adv_window", 64'(rx_adv_window), 64'(mon_e.win));
          n_cmp++;
          if (bus.tx_fix_data !== mon_e.tx_data) begin
            n_bad++;
            $display("FAIL tx_fix_data: got ...%h want ...%h", bus.tx_fix_data[63:0],
                     mon_e.tx_data[63:0]);
          end
        end
      end
      if (rst_at_edge) prev_drop = drop_cnt;
    end
  end

  initial begin : main
    bus.rx_valid = 1'b0;
    bus.rx_tcp_data = '0;
    model_reset();
    rst_n = 1'b0;
    idle(2);
    // Reset values
    chk("rst_seg_valid", 64'(seg_valid), 0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 0);
    chk("rst_csum_err", 64'(csum_err), 0);
    chk("rst_conn_state", 64'(conn_state), 0);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    chk("rst_rx_seq", 64'(rx_seq_num), 0);
    chk("rst_tx_data", bus.tx_fix_data[63:0], 0);
    rst_n = 1'b1;
    idle(1);

    // SYN, checked also for its one-edge decision latency
    build(LPORT, 32'h12341234, 32'h0, 6'h02, 16'h1000, 1, 8'h00);
    issue(1);
    @(posedge clk); #1;
    chk("syn_seg_valid_latency", 64'(seg_valid), 1);
    chk("syn_conn_state", 64'(conn_state), 1);
    chk("syn_rx_flag", 64'(rx_flag), 64'h02);

    // Handshake ACK, PUSH with 8'hA5 payload, then a replay of the same PUSH
    build(LPORT, 32'h12341235, 32'h1, 6'h10, 16'h1000, 1, 8'h00);
    issue(1);
    build(LPORT, 32'h12341236, 32'h1, 6'h18, 16'h1000, 0, 8'hA5);
    issue(1);
    issue(1);
    idle(3);
    chk("push_replay_drop_cnt", 64'(drop_cnt), 1);
    chk("est_conn_state", 64'(conn_state), 2);

    // Corrupted payload bit
    build(LPORT, m_exp, 32'h1, 6'h18, 16'h1000, 0, 8'hA5);
    sb[100] = sb[100] ^ 8'h01;
    issue(1);
    idle(3);
    chk("csum_bad_state_kept", 64'(conn_state), 2);

    // RST from ESTABLISHED
    build(LPORT, 32'hDEADBEEF, 32'h0, 6'h04, 16'h0, 1, 8'h00);
    issue(1);
    idle(3);
    chk("rst_to_listen", 64'(conn_state), 0);

    // Sequence wrap, back-to-back
    build(LPORT, 32'hFFFFFFFE, 32'h0, 6'h02, 16'h2000, 1, 8'h00);
    issue(1);
    build(LPORT, 32'hFFFFFFFF, 32'h0, 6'h10, 16'h2000, 1, 8'h00);
    issue(1);
    build(LPORT, 32'h00000000, 32'h0, 6'h18, 16'h2000, 1, 8'h00);
    issue(1);
    idle(3);
    chk("wrap_conn_state", 64'(conn_state), 2);
    chk("wrap_rx_seq", 64'(rx_seq_num), 0);

    // Reset asserted while a PUSH sits in stage 1
    build(LPORT, m_exp, 32'h0, 6'h18, 16'h2000, 1, 8'h00);
    issue(0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("inflight_tx_valid", 64'(bus.tx_valid), 0);
      chk("inflight_seg_valid", 64'(seg_valid), 0);
      idle(1);
    end
    chk("inflight_conn_state", 64'(conn_state), 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0]  fl;
      logic [31:0] seq;
      logic [15:0] dst;
      fl = 6'($urandom);
      if ($urandom_range(0, 15) != 0) fl[2] = 1'b0;
      seq = ($urandom_range(0, 3) != 0) ? m_exp : $urandom;
      dst = ($urandom_range(0, 7) != 0) ? LPORT : 16'($urandom);
      build(dst, seq, $urandom, fl, 16'($urandom), 1, 8'h00);
      if ($urandom_range(0, 7) == 0) begin
        int k;
        k = $urandom_range(0, SEG_BYTES - 1);
        sb[k] = sb[k] ^ 8'(1 << $urandom_range(0, 7));
      end
      issue(1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
